// File: rtl/memio_pkg.sv
// memio_pkg: shared state encoding, requester ids and address decode
// helper for the memory/IO bus arbiter.
package memio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        IO_WAIT,
        DONE
    } state_t;

    localparam logic [31:0] IO_BASE_DEF = 32'hFFFFFC00;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    function automatic logic is_io(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return addr >= base;
    endfunction

endpackage

// File: rtl/memio_rr_arb.sv
// memio_rr_arb: two-way arbiter, round-robin by default.
// Defining MEMIO_LDR_PRIORITY_EN gives the loader fixed priority.
module memio_rr_arb
    import memio_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_id,
    output logic [1:0] o_gnt
);

`ifdef MEMIO_LDR_PRIORITY_EN
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst_n, i_upd, i_upd_id};

    always_comb begin
        o_gnt = 2'b00;
        if (i_req[REQ_LDR]) begin
            o_gnt[REQ_LDR] = 1'b1;
        end else if (i_req[REQ_CPU]) begin
            o_gnt[REQ_CPU] = 1'b1;
        end
    end
`else
    logic r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= REQ_LDR;
        end else if (i_upd) begin
            r_last <= i_upd_id;
        end
    end

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = 2'b00;
            o_gnt[~r_last] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/memio_arbiter.sv
// memio_arbiter: shares one memory/IO bus between CPU and loader.
// Optional macro MEMIO_LDR_PRIORITY_EN: loader wins every tie.
module memio_arbiter
    import memio_pkg::*;
#(
    parameter int unsigned IO_WAIT = 2,
    parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_ack,
    output logic [31:0] c_rdata,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_ack,
    output logic [31:0] l_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_memread,
    output logic        bus_memwrite,
    output logic        bus_ioread,
    output logic        bus_iowrite,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    localparam logic [3:0] CNT_INIT = 4'(IO_WAIT);

    state_t      r_state;
    logic        r_win;
    logic        r_we;
    logic        r_io;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_c_rdata;
    logic [31:0] r_l_rdata;
    logic        r_c_ack;
    logic        r_l_ack;
    logic        r_busy;
    logic        r_mrd;
    logic        r_mwr;
    logic        r_ird;
    logic        r_iwr;

    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_accept;
    logic        w_win;
    logic        w_we;
    logic        w_io;
    logic        w_last;
    logic        w_unused;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_cap;

    assign w_req    = {l_req, c_req};
    assign w_accept = (r_state == IDLE) && (|w_req);
    assign w_win    = w_gnt[REQ_LDR];
    assign w_unused = w_gnt[REQ_CPU];
    assign w_addr   = w_win ? l_addr : c_addr;
    assign w_wdata  = w_win ? l_wdata : c_wdata;
    assign w_we     = w_win ? l_we : c_we;
    assign w_io     = is_io(w_addr, IO_BASE);
    assign w_last   = (r_state == MEM) ||
                      ((r_state == memio_pkg::IO_WAIT) && (r_cnt == 4'd1));
    // I/O devices are 16 bits wide; upper half reads back as zero.
    assign w_cap    = r_io ? {16'h0000, bus_rdata[15:0]} : bus_rdata;

    memio_rr_arb u_arb (
        .i_clk    (clock),
        .i_rst_n  (reset_n),
        .i_req    (w_req),
        .i_upd    (w_accept),
        .i_upd_id (w_win),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_win     <= REQ_CPU;
            r_we      <= 1'b0;
            r_io      <= 1'b0;
            r_cnt     <= 4'd0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_c_rdata <= 32'h0;
            r_l_rdata <= 32'h0;
            r_c_ack   <= 1'b0;
            r_l_ack   <= 1'b0;
            r_busy    <= 1'b0;
            r_mrd     <= 1'b0;
            r_mwr     <= 1'b0;
            r_ird     <= 1'b0;
            r_iwr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_win   <= w_win;
                        r_we    <= w_we;
                        r_io    <= w_io;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_busy  <= 1'b1;
                        r_mrd   <= !w_io && !w_we;
                        r_mwr   <= !w_io && w_we;
                        r_ird   <= w_io && !w_we;
                        r_iwr   <= w_io && w_we;
                        if (w_io) begin
                            r_cnt   <= CNT_INIT;
                            r_state <= memio_pkg::IO_WAIT;
                        end else begin
                            r_state <= MEM;
                        end
                    end
                end
                MEM, memio_pkg::IO_WAIT: begin
                    if (w_last) begin
                        r_mrd   <= 1'b0;
                        r_mwr   <= 1'b0;
                        r_ird   <= 1'b0;
                        r_iwr   <= 1'b0;
                        r_cnt   <= 4'd0;
                        r_state <= DONE;
                        if (r_win == REQ_LDR) begin
                            r_l_ack <= 1'b1;
                            if (!r_we) r_l_rdata <= w_cap;
                        end else begin
                            r_c_ack <= 1'b1;
                            if (!r_we) r_c_rdata <= w_cap;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_c_ack <= 1'b0;
                    r_l_ack <= 1'b0;
                    r_addr  <= 32'h0;
                    r_wdata <= 32'h0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign c_ack        = r_c_ack;
    assign l_ack        = r_l_ack;
    assign c_rdata      = r_c_rdata;
    assign l_rdata      = r_l_rdata;
    assign bus_addr     = r_addr;
    assign bus_wdata    = r_wdata;
    assign bus_memread  = r_mrd;
    assign bus_memwrite = r_mwr;
    assign bus_ioread   = r_ird;
    assign bus_iowrite  = r_iwr;
    assign busy         = r_busy;

endmodule
